// File: rtl/if_id_elastic_if.sv
// Fetch-to-decode handshake bundle for if_id_elastic.
// The stage takes the slave modport; the fetch/decode environment takes master.
interface if_id_elastic_if #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned IMM_W  = 12,
    parameter int unsigned CNT_W  = 16
);
    logic              up_valid_i;
    logic              up_ready_o;
    logic [PC_W-1:0]   pc_i;
    logic [INST_W-1:0] inst_i;
    logic [IMM_W-1:0]  pcIm_i;
    logic              dn_valid_o;
    logic              dn_ready_i;
    logic [PC_W-1:0]   pc_o;
    logic [INST_W-1:0] inst_o;
    logic [IMM_W-1:0]  pcIm_o;
    logic [1:0]        occ_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport slave (
        input  up_valid_i, pc_i, inst_i, pcIm_i, dn_ready_i,
        output up_ready_o, dn_valid_o, pc_o, inst_o, pcIm_o, occ_o, stall_cnt_o
    );

    modport master (
        output up_valid_i, pc_i, inst_i, pcIm_i, dn_ready_i,
        input  up_ready_o, dn_valid_o, pc_o, inst_o, pcIm_o, occ_o, stall_cnt_o
    );
endinterface

// File: rtl/if_id_elastic.sv
// Elastic IF/ID stage: main + skid register, registered up_ready_o,
// flush-to-bubble and a saturating decode-stall counter.
module if_id_elastic #(
    parameter int unsigned        PC_W   = 32,
    parameter int unsigned        INST_W = 32,
    parameter int unsigned        IMM_W  = 12,
    parameter logic [INST_W-1:0]  BUBBLE = {INST_W{1'b0}},
    parameter int unsigned        CNT_W  = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    if_id_elastic_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            r_state;
    logic              r_up_ready;
    logic              r_dn_valid;
    logic [1:0]        r_occ;
    logic [PC_W-1:0]   r_pc;
    logic [INST_W-1:0] r_inst;
    logic [IMM_W-1:0]  r_imm;
    logic [PC_W-1:0]   r_skid_pc;
    logic [INST_W-1:0] r_skid_inst;
    logic [IMM_W-1:0]  r_skid_imm;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic   w_up_fire;
    logic   w_dn_fire;
    logic   w_stall;
    state_t w_next_state;

    assign w_up_fire = bus.up_valid_i & r_up_ready;
    assign w_dn_fire = r_dn_valid & bus.dn_ready_i;
    assign w_stall   = r_dn_valid & ~bus.dn_ready_i;

    // Next state; flush always empties the stage.
    always_comb begin
        w_next_state = r_state;
        if (flush_i) begin
            w_next_state = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: if (w_up_fire) w_next_state = FULL;
                FULL: begin
                    if (w_dn_fire && !w_up_fire)      w_next_state = EMPTY;
                    else if (w_up_fire && !w_dn_fire) w_next_state = SKID;
                end
                SKID:    if (w_dn_fire) w_next_state = FULL;
                default: w_next_state = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= EMPTY;
            r_up_ready  <= 1'b1;
            r_dn_valid  <= 1'b0;
            r_occ       <= 2'd0;
            r_pc        <= '0;
            r_inst      <= '0;
            r_imm       <= '0;
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
            r_skid_imm  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_up_ready <= (w_next_state != SKID);
            r_dn_valid <= (w_next_state != EMPTY);
            r_occ      <= (w_next_state == SKID) ? 2'd2 :
                          (w_next_state == FULL) ? 2'd1 : 2'd0;

            // Counts on current outputs, flush cycles included.
            if (w_stall && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);

            if (flush_i) begin
                r_inst <= BUBBLE;
                r_imm  <= '0;
            end else begin
                unique case (r_state)
                    EMPTY: if (w_up_fire) begin
                        r_pc   <= bus.pc_i;
                        r_inst <= bus.inst_i;
                        r_imm  <= bus.pcIm_i;
                    end
                    FULL: begin
                        if (w_up_fire && w_dn_fire) begin
                            r_pc   <= bus.pc_i;
                            r_inst <= bus.inst_i;
                            r_imm  <= bus.pcIm_i;
                        end else if (w_up_fire) begin
                            r_skid_pc   <= bus.pc_i;
                            r_skid_inst <= bus.inst_i;
                            r_skid_imm  <= bus.pcIm_i;
                        end
                    end
                    SKID: if (w_dn_fire) begin
                        r_pc   <= r_skid_pc;
                        r_inst <= r_skid_inst;
                        r_imm  <= r_skid_imm;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.up_ready_o  = r_up_ready;
    assign bus.dn_valid_o  = r_dn_valid;
    assign bus.occ_o       = r_occ;
    assign bus.pc_o        = r_pc;
    assign bus.inst_o      = r_inst;
    assign bus.pcIm_o      = r_imm;
    assign bus.stall_cnt_o = r_stall_cnt;
endmodule

// File: tb/tb_if_id_elastic.sv
// Directed bench for if_id_elastic with hand-computed expectations (CNT_W=4).
module tb_if_id_elastic;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned IMM_W  = 12;
    localparam int unsigned CNT_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    if_id_elastic_if #(.PC_W(PC_W), .INST_W(INST_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) bus ();

    if_id_elastic #(
        .PC_W(PC_W), .INST_W(INST_W), .IMM_W(IMM_W),
        .BUBBLE({INST_W{1'b0}}), .CNT_W(CNT_W)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .flush_i(flush),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [11:0] imm);
        bus.up_valid_i = v;
        bus.pc_i       = pc;
        bus.inst_i     = inst;
        bus.pcIm_i     = imm;
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 12'h0);
        bus.dn_ready_i = 1'b0;

        // Reset, with a handshake attempt that must be ignored.
        rst = 1'b1;
        drive(1'b1, 32'hDEAD, 32'hBEEF, 12'h7);
        bus.dn_ready_i = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 12'h0);
        chk("rst_dn_valid", 64'(bus.dn_valid_o), 64'd0);
        chk("rst_up_ready", 64'(bus.up_ready_o), 64'd1);
        chk("rst_occ",      64'(bus.occ_o), 64'd0);
        chk("rst_pc",       64'(bus.pc_o), 64'd0);
        chk("rst_inst",     64'(bus.inst_o), 64'd0);
        chk("rst_imm",      64'(bus.pcIm_o), 64'd0);
        chk("rst_stall",    64'(bus.stall_cnt_o), 64'd0);

        // Stream three beats at full throughput.
        bus.dn_ready_i = 1'b1;
        drive(1'b1, 32'h100, 32'hA, 12'h1);
        tick();
        chk("s0_valid", 64'(bus.dn_valid_o), 64'd1);
        chk("s0_pc",    64'(bus.pc_o), 64'h100);
        chk("s0_inst",  64'(bus.inst_o), 64'hA);
        chk("s0_imm",   64'(bus.pcIm_o), 64'h1);
        drive(1'b1, 32'h104, 32'hB, 12'h2);
        tick();
        chk("s1_pc",  64'(bus.pc_o), 64'h104);
        chk("s1_occ", 64'(bus.occ_o), 64'd1);
        drive(1'b1, 32'h108, 32'hC, 12'h3);
        tick();
        chk("s2_pc",   64'(bus.pc_o), 64'h108);
        chk("s2_inst", 64'(bus.inst_o), 64'hC);
        chk("s2_occ",  64'(bus.occ_o), 64'd1);
        drive(1'b0, 32'h0, 32'h0, 12'h0);
        tick();
        chk("s3_valid", 64'(bus.dn_valid_o), 64'd0);
        chk("s3_hold",  64'(bus.pc_o), 64'h108);
        chk("s3_stall", 64'(bus.stall_cnt_o), 64'd0);

        // Backpressure fills the skid register.
        bus.dn_ready_i = 1'b0;
        drive(1'b1, 32'h100, 32'h10, 12'h4);
        tick();
        chk("bp0_pc",    64'(bus.pc_o), 64'h100);
        chk("bp0_ready", 64'(bus.up_ready_o), 64'd1);
        drive(1'b1, 32'h104, 32'h11, 12'h5);
        tick();
        drive(1'b0, 32'h0, 32'h0, 12'h0);
        chk("bp1_occ",   64'(bus.occ_o), 64'd2);
        chk("bp1_ready", 64'(bus.up_ready_o), 64'd0);
        chk("bp1_pc",    64'(bus.pc_o), 64'h100);
        chk("bp1_stall", 64'(bus.stall_cnt_o), 64'd1);
        tick();
        chk("bp2_pc",    64'(bus.pc_o), 64'h100);
        chk("bp2_stall", 64'(bus.stall_cnt_o), 64'd2);
        bus.dn_ready_i = 1'b1;
        tick();
        chk("bp3_pc",    64'(bus.pc_o), 64'h104);
        chk("bp3_inst",  64'(bus.inst_o), 64'h11);
        chk("bp3_imm",   64'(bus.pcIm_o), 64'h5);
        chk("bp3_occ",   64'(bus.occ_o), 64'd1);
        chk("bp3_ready", 64'(bus.up_ready_o), 64'd1);
        tick();
        chk("bp4_valid", 64'(bus.dn_valid_o), 64'd0);
        chk("bp4_stall", 64'(bus.stall_cnt_o), 64'd2);

        // Flush while in SKID with a concurrent upstream beat.
        bus.dn_ready_i = 1'b0;
        drive(1'b1, 32'h300, 32'h30, 12'h6);
        tick();
        drive(1'b1, 32'h304, 32'h31, 12'h7);
        tick();
        chk("fl0_occ", 64'(bus.occ_o), 64'd2);
        flush = 1'b1;
        drive(1'b1, 32'h200, 32'h20, 12'h8);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 12'h0);
        chk("fl1_valid", 64'(bus.dn_valid_o), 64'd0);
        chk("fl1_inst",  64'(bus.inst_o), 64'd0);
        chk("fl1_imm",   64'(bus.pcIm_o), 64'd0);
        chk("fl1_occ",   64'(bus.occ_o), 64'd0);
        chk("fl1_ready", 64'(bus.up_ready_o), 64'd1);
        chk("fl1_pc",    64'(bus.pc_o), 64'h300);
        chk("fl1_stall", 64'(bus.stall_cnt_o), 64'd4);
        bus.dn_ready_i = 1'b1;
        tick();
        chk("fl2_valid", 64'(bus.dn_valid_o), 64'd0);
        chk("fl2_pc",    64'(bus.pc_o), 64'h300);

        // Simultaneous up and down fire in FULL.
        drive(1'b1, 32'h100, 32'h40, 12'h9);
        tick();
        chk("sf0_pc", 64'(bus.pc_o), 64'h100);
        drive(1'b1, 32'h104, 32'h41, 12'hA);
        tick();
        drive(1'b0, 32'h0, 32'h0, 12'h0);
        chk("sf1_pc",    64'(bus.pc_o), 64'h104);
        chk("sf1_occ",   64'(bus.occ_o), 64'd1);
        chk("sf1_ready", 64'(bus.up_ready_o), 64'd1);
        tick();
        chk("sf2_occ", 64'(bus.occ_o), 64'd0);

        // Stall counter saturates at 15.
        bus.dn_ready_i = 1'b0;
        drive(1'b1, 32'h400, 32'h50, 12'hB);
        tick();
        drive(1'b0, 32'h0, 32'h0, 12'h0);
        chk("sat0_stall", 64'(bus.stall_cnt_o), 64'd4);
        for (int i = 0; i < 20; i++) tick();
        chk("sat1_stall", 64'(bus.stall_cnt_o), 64'd15);
        chk("sat1_pc",    64'(bus.pc_o), 64'h400);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sat2_stall", 64'(bus.stall_cnt_o), 64'd15);
        chk("sat2_occ",   64'(bus.occ_o), 64'd0);

        // Reset dominates flush while in SKID.
        drive(1'b1, 32'h500, 32'h60, 12'hC);
        tick();
        drive(1'b1, 32'h504, 32'h61, 12'hD);
        tick();
        chk("rm0_occ", 64'(bus.occ_o), 64'd2);
        rst = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h600, 32'h70, 12'hE);
        tick();
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 12'h0);
        chk("rm1_valid", 64'(bus.dn_valid_o), 64'd0);
        chk("rm1_ready", 64'(bus.up_ready_o), 64'd1);
        chk("rm1_occ",   64'(bus.occ_o), 64'd0);
        chk("rm1_pc",    64'(bus.pc_o), 64'd0);
        chk("rm1_inst",  64'(bus.inst_o), 64'd0);
        chk("rm1_imm",   64'(bus.pcIm_o), 64'd0);
        chk("rm1_stall", 64'(bus.stall_cnt_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
